// File: rtl/sm_arith_pkg.sv
// ============================================================================
// Module      : sm_arith_pkg
// Description : Shared types and helpers for the sign-magnitude multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sm_state_t;

  // Widest magnitude the sign-fix helper accepts; callers zero-extend.
  localparam int unsigned MAG_MAX_W = 128;

  function automatic int unsigned sm_prod_w(input int unsigned w);
    return 2 * w - 1;
  endfunction

  function automatic int unsigned sm_cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  function automatic logic sm_neg_zero_fix(input logic sign,
                                           input logic [MAG_MAX_W-1:0] mag);
    return sign & (|mag);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_shift_add_core.sv
// ============================================================================
// Module      : sm_shift_add_core
// Description : Magnitude shift-add datapath, one multiplier bit per step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_shift_add_core
  import sm_arith_pkg::*;
#(
  parameter int W          = 4,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-2:0]   a_mag,
  input  logic [W-2:0]   b_mag,
  output logic [2*W-3:0] acc_nxt,
  output logic           done_bits
);

  localparam int unsigned c_m  = W - 1;
  localparam int unsigned c_cw = sm_cnt_w(W);
  localparam logic [c_cw-1:0] c_last = c_cw'(W - 2);

  logic [2*c_m-1:0] r_mcand;
  logic [2*c_m-1:0] r_acc;
  logic [c_m-1:0]   r_mplier;
  logic [c_cw-1:0]  r_cnt;
  logic [c_m-1:0]   w_mplier_shr;

  // done_bits flags that the step being taken now is the final one.
  always_comb begin
    w_mplier_shr = r_mplier >> 1;
    acc_nxt      = r_acc + (r_mplier[0] ? r_mcand : '0);
    done_bits    = (r_cnt == c_last);
    if (EARLY_EXIT) begin
      done_bits = done_bits | (w_mplier_shr == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_mcand  <= {{c_m{1'b0}}, a_mag};
      r_acc    <= '0;
      r_mplier <= b_mag;
      r_cnt    <= '0;
    end else if (step) begin
      r_acc    <= acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_shr;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_sm_multiplier.sv
// ============================================================================
// Module      : serial_sm_multiplier
// Description : Sequential sign-magnitude multiplier with valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sm_multiplier
  import sm_arith_pkg::*;
#(
  parameter int W          = 4,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*W-2:0]      p,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int unsigned c_pw = sm_prod_w(W);

  sm_state_t         r_state;
  sm_state_t         w_state_nxt;
  logic              r_sign;
  logic [c_pw-1:0]   r_p;
  logic              r_out_valid;
  logic              w_load;
  logic              w_step;
  logic              w_done_bits;
  logic [2*W-3:0]    w_acc_nxt;
  logic              w_sign_fixed;

  sm_shift_add_core #(
    .W          (W),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .step      (w_step),
    .a_mag     (a[W-2:0]),
    .b_mag     (b[W-2:0]),
    .acc_nxt   (w_acc_nxt),
    .done_bits (w_done_bits)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (w_done_bits) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A zero magnitude never carries a negative sign.
  assign w_sign_fixed = sm_neg_zero_fix(r_sign, MAG_MAX_W'(w_acc_nxt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_sign <= a[W-1] ^ b[W-1];
      end
      if (r_state == CALC && w_done_bits) begin
        r_p         <= {w_sign_fixed, w_acc_nxt};
        r_out_valid <= 1'b1;
      end else if (r_state == DONE && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == CALC);
  assign p         = r_p;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_serial_sm_multiplier.sv
// ============================================================================
// Module      : tb_serial_sm_multiplier
// Description : Directed self-checking bench for serial_sm_multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sm_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        iv4 = 1'b0, iv4e = 1'b0, out_ready4 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        iv8 = 1'b0, out_ready8 = 1'b1;
  logic        ir4, ov4, bz4, ir4e, ov4e, bz4e, ir8, ov8, bz8;
  logic [6:0]  p4, p4e;
  logic [14:0] p8;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_sm_multiplier #(.W(4), .EARLY_EXIT(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(iv4), .in_ready(ir4),
    .p(p4), .out_valid(ov4), .out_ready(out_ready4), .busy(bz4));

  serial_sm_multiplier #(.W(4), .EARLY_EXIT(1'b1)) u4e (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(iv4e), .in_ready(ir4e),
    .p(p4e), .out_valid(ov4e), .out_ready(out_ready4), .busy(bz4e));

  serial_sm_multiplier #(.W(8), .EARLY_EXIT(1'b1)) u8e (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8), .in_ready(ir8),
    .p(p8), .out_valid(ov8), .out_ready(out_ready8), .busy(bz8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_p(input int sel);
    case (sel)
      0:       return 64'(p4);
      1:       return 64'(p4e);
      default: return 64'(p8);
    endcase
  endfunction

  function automatic logic obs_valid(input int sel);
    case (sel)
      0:       return ov4;
      1:       return ov4e;
      default: return ov8;
    endcase
  endfunction

  function automatic logic obs_ready(input int sel);
    case (sel)
      0:       return ir4;
      1:       return ir4e;
      default: return ir8;
    endcase
  endfunction

  function automatic logic obs_busy(input int sel);
    case (sel)
      0:       return bz4;
      1:       return bz4e;
      default: return bz8;
    endcase
  endfunction

  // One full transaction with out_ready held high; latency counted in edges after acceptance.
  task automatic op(input int sel, input logic [7:0] a, input logic [7:0] b,
                    input int exp_lat, input logic [14:0] exp_p, input string tag);
    int n;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(obs_ready(sel)), 64'd1);
    if (sel == 2) begin
      a8 = a; b8 = b; iv8 = 1'b1;
    end else begin
      a4 = a[3:0]; b4 = b[3:0];
      if (sel == 0) iv4 = 1'b1; else iv4e = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0; iv4e = 1'b0; iv8 = 1'b0;
    check({tag, ".busy"}, 64'(obs_busy(sel)), 64'd1);
    n = 0;
    while (!obs_valid(sel) && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, ".latency"}, 64'(n), 64'(exp_lat));
    check({tag, ".p"}, obs_p(sel), 64'(exp_p));
    @(posedge clk);
    @(negedge clk);
    check({tag, ".pulse"}, 64'(obs_valid(sel)), 64'd0);
  endtask

  initial begin
    logic [6:0]  ma, mb;
    logic [13:0] mag;
    logic        sg;
    int          lat;
    int          idx;

    // Reset state
    #12;
    check("rst.in_ready", 64'(ir4), 64'd1);
    check("rst.out_valid", 64'(ov4), 64'd0);
    check("rst.p", 64'(p4), 64'd0);
    check("rst.busy", 64'(bz4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic products, W=4, no early exit
    op(0, 8'b0001, 8'b1011, 3, 15'b1000011, "t1_1xm3");
    op(0, 8'b1111, 8'b1111, 3, 15'b0110001, "t2_m7xm7");
    op(0, 8'b1111, 8'b0111, 3, 15'b1110001, "t2_m7x7");
    op(0, 8'b1000, 8'b0011, 3, 15'b0000000, "t3_m0x3");
    op(0, 8'b1000, 8'b0000, 3, 15'b0000000, "t3_m0x0");
    op(0, 8'b0101, 8'b1000, 3, 15'b0000000, "t3_5xm0");
    op(0, 8'b0011, 8'b0000, 3, 15'b0000000, "t3_3x0_nee");

    // Backpressure: result held, in_valid pulses ignored
    @(negedge clk);
    out_ready4 = 1'b0;
    a4 = 4'b0010; b4 = 4'b0111; iv4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4.valid", 64'(ov4), 64'd1);
    check("t4.p", 64'(p4), 64'b0001110);
    for (int i = 0; i < 5; i++) begin
      iv4 = i[0]; a4 = 4'b1111; b4 = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      check("t4.hold_valid", 64'(ov4), 64'd1);
      check("t4.hold_p", 64'(p4), 64'b0001110);
      check("t4.hold_in_ready", 64'(ir4), 64'd0);
    end
    iv4 = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4.consumed_valid", 64'(ov4), 64'd0);
    check("t4.consumed_in_ready", 64'(ir4), 64'd1);
    check("t4.p_kept", 64'(p4), 64'b0001110);

    // Asynchronous reset during the second CALC cycle
    @(negedge clk);
    a4 = 4'b0011; b4 = 4'b0101; iv4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5.out_valid", 64'(ov4), 64'd0);
    check("t5.p", 64'(p4), 64'd0);
    check("t5.in_ready", 64'(ir4), 64'd1);
    check("t5.busy", 64'(bz4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 8'b0011, 8'b0101, 3, 15'b0001111, "t5_after");

    // Early exit, W=4
    op(1, 8'b0011, 8'b0001, 1, 15'b0000011, "t6_ee_b1");
    op(1, 8'b1011, 8'b0000, 1, 15'b0000000, "t6_ee_b0");
    op(1, 8'b1011, 8'b0010, 2, 15'b1000110, "t6_ee_b2");
    op(1, 8'b0101, 8'b1100, 3, 15'b1010100, "t6_ee_bm4");

    // W=8 early exit: all sign combinations against a reference model
    idx = 0;
    for (int sa = 0; sa < 2; sa++) begin
      for (int sb = 0; sb < 2; sb++) begin
        for (int k = 0; k < 6; k++) begin
          ma = (k == 0) ? 7'd0 : 7'($urandom_range(0, 127));
          mb = (k == 1) ? 7'd0 : (k == 2) ? 7'd127 : 7'($urandom_range(0, 127));
          mag = 14'(ma) * 14'(mb);
          sg = (sa[0] ^ sb[0]) & (mag != 14'd0);
          lat = 1;
          for (int j = 0; j < 7; j++) begin
            if (mb[j]) lat = j + 1;
          end
          op(2, {sa[0], ma}, {sb[0], mb}, lat, {sg, mag}, $sformatf("w8_%0d", idx));
          idx++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
